// File: rtl/bb_mem_slave.sv
// Blackbone bus memory slave: configurable width/depth, fixed wait-state latency,
// byte-lane writes and an error response for addresses beyond DEPTH.
module bb_mem_slave #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  mclk,
  input  logic                  puc_rst,
  input  logic                  per_en,
  input  logic [DATA_W/8-1:0]   per_we,
  input  logic [ADDR_W-1:0]     per_addr,
  input  logic [DATA_W-1:0]     per_din,
  output logic [DATA_W-1:0]     per_dout,
  output logic                  per_rdy,
  output logic                  per_err
);

  localparam int LANES = DATA_W / 8;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [LANES-1:0]    we_q;
  logic [DATA_W-1:0]   din_q;
  logic                rdy_q, rdy_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   dout_q, dout_d;

  logic                accept, enter_resp, in_range, wr_en;
  logic [ADDR_W-1:0]   eff_addr;
  logic [LANES-1:0]    eff_we;
  logic [DATA_W-1:0]   eff_din;

  logic [DATA_W-1:0]   mem [DEPTH];

  assign accept = (state_q == S_IDLE) && per_en;

  // With zero wait states the RESP-entry edge is the accept edge, so use the live inputs then.
  assign eff_addr = (state_q == S_IDLE) ? per_addr : addr_q;
  assign eff_we   = (state_q == S_IDLE) ? per_we   : we_q;
  assign eff_din  = (state_q == S_IDLE) ? per_din  : din_q;

  assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign in_range   = ({1'b0, eff_addr} < DEPTH_L);
  assign wr_en      = enter_resp && in_range && (eff_we != '0) && puc_rst;

  always_ff @(posedge mclk or negedge puc_rst) begin
    if (!puc_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (per_en) begin
          if (WAIT_CYCLES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdy_d  = enter_resp;
    err_d  = enter_resp && !in_range;
    dout_d = '0;
    if (enter_resp && in_range && (eff_we == '0)) dout_d = mem[eff_addr];
  end

  always_ff @(posedge mclk or negedge puc_rst) begin
    if (!puc_rst) begin
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
      dout_q <= '0;
    end else begin
      rdy_q  <= rdy_d;
      err_q  <= err_d;
      dout_q <= dout_d;
    end
  end

  // Request fields are captured only at accept; later bus activity is ignored.
  always_ff @(posedge mclk) begin
    if (accept) begin
      addr_q <= per_addr;
      we_q   <= per_we;
      din_q  <= per_din;
    end
  end

  always_ff @(posedge mclk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (eff_we[i]) mem[eff_addr][8*i +: 8] <= eff_din[8*i +: 8];
      end
    end
  end

  assign per_rdy  = rdy_q;
  assign per_err  = err_q;
  assign per_dout = dout_q;

endmodule

// File: tb/tb_bb_mem_slave.sv
// Self-checking bench for bb_mem_slave (DATA_W=32, ADDR_W=8, DEPTH=192, WAIT_CYCLES=2).
module tb_bb_mem_slave;

  localparam int DEPTH = 192;
  localparam int EXP_LAT = 3;

  logic        mclk = 1'b0;
  logic        puc_rst;
  logic        per_en;
  logic [3:0]  per_we;
  logic [7:0]  per_addr;
  logic [31:0] per_din;
  logic [31:0] per_dout;
  logic        per_rdy;
  logic        per_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ref_mem [256];

  typedef struct {
    logic [3:0]  we;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_err;
  } vec_t;

  bb_mem_slave #(.DATA_W(32), .ADDR_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(2)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .per_en(per_en), .per_we(per_we),
    .per_addr(per_addr), .per_din(per_din), .per_dout(per_dout),
    .per_rdy(per_rdy), .per_err(per_err)
  );

  always #5 mclk = ~mclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pattern(input int a);
    logic [7:0] b;
    b = 8'(a);
    return {b, b ^ 8'h5A, ~b, b + 8'd3};
  endfunction

  // Reference: error if beyond DEPTH, otherwise merge enabled bytes or return stored word.
  task automatic model(input logic [3:0] we, input logic [7:0] addr, input logic [31:0] din,
                       output logic [31:0] exp_dout, output logic exp_err);
    exp_err  = (int'(addr) >= DEPTH);
    exp_dout = 32'h0;
    if (!exp_err) begin
      if (we == 4'h0) exp_dout = ref_mem[addr];
      else for (int i = 0; i < 4; i++) if (we[i]) ref_mem[addr][8*i +: 8] = din[8*i +: 8];
    end
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic xfer(input logic [3:0] we, input logic [7:0] addr, input logic [31:0] din,
                      output logic [31:0] dout, output logic err, output int lat, output bit post_ok);
    per_we = we; per_addr = addr; per_din = din; per_en = 1'b1;
    @(posedge mclk);
    lat = -1; dout = 'x; err = 'x;
    for (int n = 1; n <= 20; n++) begin
      @(negedge mclk);
      if (per_rdy) begin
        lat = n; dout = per_dout; err = per_err;
        break;
      end
    end
    per_en = 1'b0;
    @(negedge mclk);
    post_ok = !per_rdy && (per_dout == 32'h0) && !per_err;
  endtask

  task automatic run_check(input string nm, input logic [3:0] we, input logic [7:0] addr,
                           input logic [31:0] din, input logic [31:0] exp_dout, input logic exp_err);
    logic [31:0] d; logic e; int lat; bit ok;
    xfer(we, addr, din, d, e, lat, ok);
    chk({nm, " dout"}, d, exp_dout);
    chk({nm, " err"}, 32'(e), 32'(exp_err));
    chk({nm, " latency"}, 32'(lat), 32'(EXP_LAT));
    chk({nm, " one-cycle"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs [8];
    logic [31:0] ed, d; logic ee, e; int lat; bit ok;
    int idx, last;

    // Reset held with a request pending: outputs stay cleared.
    puc_rst = 1'b0; per_en = 1'b1; per_we = 4'hF; per_addr = 8'h05; per_din = 32'hFFFFFFFF;
    for (int c = 0; c < 3; c++) begin
      @(negedge mclk);
      chk("reset rdy", 32'(per_rdy), 32'd0);
      chk("reset err", 32'(per_err), 32'd0);
      chk("reset dout", per_dout, 32'd0);
    end
    per_en = 1'b0;
    puc_rst = 1'b1;
    @(negedge mclk);

    for (int a = 0; a < DEPTH; a++) begin
      xfer(4'hF, 8'(a), pattern(a), d, e, lat, ok);
      model(4'hF, 8'(a), pattern(a), ed, ee);
    end

    vecs[0] = '{4'hF, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{4'h0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{4'hF, 8'h20, 32'h11223344, 32'h0,        1'b0};
    vecs[3] = '{4'h5, 8'h20, 32'hAABBCCDD, 32'h0,        1'b0};
    vecs[4] = '{4'h0, 8'h20, 32'h0,        32'h11BB33DD, 1'b0};
    vecs[5] = '{4'hF, 8'hC0, 32'h12345678, 32'h0,        1'b1};
    vecs[6] = '{4'h0, 8'hC0, 32'h0,        32'h0,        1'b1};
    vecs[7] = '{4'h0, 8'h00, 32'h0,        pattern(0),   1'b0};
    for (int i = 0; i < 8; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].din,
                vecs[i].exp_dout, vecs[i].exp_err);
      model(vecs[i].we, vecs[i].addr, vecs[i].din, ed, ee);
    end

    // Back-to-back reads with per_en held high.
    per_we = 4'h0; per_addr = 8'h00; per_en = 1'b1;
    idx = 0; last = 0;
    for (int c = 0; c < 60 && idx < 8; c++) begin
      @(negedge mclk);
      if (per_rdy) begin
        chk($sformatf("b2b dout%0d", idx), per_dout, ref_mem[idx]);
        if (idx > 0) chk("b2b gap", 32'(c - last), 32'd4);
        last = c;
        idx++;
        if (idx < 8) per_addr = 8'(idx);
        else per_en = 1'b0;
      end
    end
    chk("b2b count", 32'(idx), 32'd8);
    per_en = 1'b0;
    @(negedge mclk);

    // Reset during the response cycle clears the outputs asynchronously.
    per_we = 4'h0; per_addr = 8'h10; per_en = 1'b1;
    @(posedge mclk);
    idx = 0;
    for (int n = 0; n < 20 && !per_rdy; n++) @(negedge mclk);
    chk("resp before reset", 32'(per_rdy), 32'd1);
    per_en = 1'b0;
    puc_rst = 1'b0;
    #1;
    chk("async reset rdy", 32'(per_rdy), 32'd0);
    chk("async reset dout", per_dout, 32'd0);
    @(negedge mclk);
    puc_rst = 1'b1;
    @(negedge mclk);

    // Write aborted by reset during WAIT must not reach memory.
    run_check("clear 0x30", 4'hF, 8'h30, 32'h0, 32'h0, 1'b0);
    model(4'hF, 8'h30, 32'h0, ed, ee);
    per_we = 4'hF; per_addr = 8'h30; per_din = 32'hCAFEF00D; per_en = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    puc_rst = 1'b0;
    #1;
    chk("mid reset rdy", 32'(per_rdy), 32'd0);
    @(negedge mclk);
    chk("mid reset rdy held", 32'(per_rdy), 32'd0);
    per_en = 1'b0;
    @(negedge mclk);
    puc_rst = 1'b1;
    @(negedge mclk);
    run_check("read 0x30 after reset", 4'h0, 8'h30, 32'h0, 32'h0, 1'b0);
    run_check("read 0x05 after reset", 4'h0, 8'h05, 32'h0, ref_mem[5], 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      logic [3:0] we; logic [7:0] ad; logic [31:0] dn;
      we = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      ad = 8'($urandom_range(0, 199));
      dn = $urandom;
      model(we, ad, dn, ed, ee);
      run_check($sformatf("rand%0d", i), we, ad, dn, ed, ee);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bb_mem_slave.md
# bb_mem_slave

Parametrised Blackbone bus memory slave with wait states, byte-lane write enables and out-of-range error response. It sits on the peripheral bus behind the master bridge as a drop-in target for testbench and SoC integration. It generalises the fixed 32-bit/256-word slave to configurable width, depth and latency, and replaces the implicit two-phase timing with an explicit ready handshake.

## Interface

- DATA_W, 32, data width in bits; multiple of 8, range 8..64
- ADDR_W, 8, word-address width
- DEPTH, 256, number of implemented words; 1 ≤ DEPTH ≤ 2**ADDR_W
- WAIT_CYCLES, 0, extra cycles between accept and response; range 0..15

Ports:

- mclk  in  1  bus clock; all state changes on its rising edge
- puc_rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- per_en  in  1  transfer request; held by master until per_rdy seen
- per_we  in  DATA_W/8  byte-lane write enables; all-zero = read
- per_addr  in  ADDR_W  word address
- per_din  in  DATA_W  write data
- per_dout  out  DATA_W  read data; valid only while per_rdy=1, else 0
- per_rdy  out  1  one-cycle response strobe
- per_err  out  1  error flag, qualified by per_rdy

## Operation

- States: IDLE, WAIT, RESP; 4-bit wait counter.
- IDLE, per_en=1 at a clock edge:
  - latch per_addr, per_we, per_din
  - go to WAIT with counter=WAIT_CYCLES-1, or straight to RESP if WAIT_CYCLES=0
- IDLE, per_en=0: stay in IDLE.
- WAIT: decrement the counter each edge. At the edge where counter=0, go to RESP.
- On the edge that enters RESP, the following are registered:
  - per_rdy=1
  - per_err=1 iff latched address ≥ DEPTH
  - write (per_we≠0, no error): mem[addr] lanes i with per_we[i]=1 take per_din lane i; other lanes unchanged
  - read (per_we=0, no error): per_dout = mem[addr]
  - write or error: per_dout=0
  - an error access never modifies memory
- RESP: lasts exactly one cycle, ignores per_en, next edge returns to IDLE and clears per_rdy, per_err and per_dout.
- Inputs are sampled only at accept. Changes to per_en, addr, we or din during WAIT/RESP have no effect. There is no abort: a transaction, once accepted, always completes.
- Reset asserted in any state:
  - immediately: state=IDLE, counter=0, per_rdy=0, per_err=0, per_dout=0
  - a pending write is discarded
  - memory contents are not reset and are undefined after power-up

## Timing

- Accept edge E0 (IDLE, per_en=1). per_rdy is high during the cycle following edge E0+WAIT_CYCLES. Latency from accept to response = WAIT_CYCLES+1 cycles.
- Master drops per_en, or presents a new request, at the edge that ends the per_rdy cycle. IDLE samples per_en at the next edge.
- Maximum throughput: one transfer every WAIT_CYCLES+2 cycles. A continuously held per_en produces back-to-back transfers at this rate.
- Read-after-write to the same address returns the new data: the write commits at the RESP-entry edge, before any later accept.
- Reset deassertion is synchronous to mclk externally. The first accept is possible at the first edge with puc_rst=1.

## Test plan

Bench configuration: DATA_W=32, ADDR_W=8, DEPTH=192, WAIT_CYCLES=2.

- Reset: hold puc_rst=0 for 3 cycles with per_en=1 -> per_rdy=0, per_err=0, per_dout=0 throughout; no memory write.
- Full write then read:
  - write addr 0x10, per_we=4'hF, din=32'hDEADBEEF -> per_rdy exactly 3 cycles after accept edge, per_dout=0, per_err=0
  - read 0x10 -> per_dout=32'hDEADBEEF for one cycle only
- Byte lanes: write 32'h11223344 to 0x20, then per_we=4'b0101 with din=32'hAABBCCDD -> read returns 32'h11BB33DD.
- Out-of-range: write 0xC0 (=DEPTH) -> per_err=1 with per_rdy; a following read of 0xC0 -> per_err=1, per_dout=0; read of 0x00 unaffected.
- Back-to-back: per_en held high for 8 reads at 0x00..0x07 -> per_rdy pulses every 4 cycles; per_dout matches preloaded data in order.
- Reset mid-operation:
  - write 0x30 with 32'h0 and complete it
  - accept a write of 32'hCAFEF00D to 0x30, assert puc_rst=0 during WAIT, release
  - read 0x30 -> 32'h0; per_rdy=0 immediately on reset
